// File: rtl/sram1024x18_pkg.sv
// Shared widths and types for the two-requester arbiter in front of a
// 1024x18 single-port SRAM.
package sram1024x18_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 18;

    typedef logic [0:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_entry_t;

    localparam rd_entry_t RD_EMPTY = '{valid: 1'b0, id: 1'b0};

endpackage

// File: rtl/sram1024x18_port_arb_if.sv
// Requester ports, response ports and the SRAM port of the arbiter.
// The slave modport is the arbiter's view; master is the environment's.
interface sram1024x18_port_arb_if;
    import sram1024x18_pkg::*;

    logic              rq0_valid, rq0_ready, rq0_we;
    logic [ADDR_W-1:0] rq0_addr;
    logic [DATA_W-1:0] rq0_wdata, rq0_wbe;
    logic              rq1_valid, rq1_ready, rq1_we;
    logic [ADDR_W-1:0] rq1_addr;
    logic [DATA_W-1:0] rq1_wdata, rq1_wbe;

    logic              rs0_valid, rs1_valid;
    logic [DATA_W-1:0] rs0_rdata, rs1_rdata;

    logic              sram_cen, sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wmsk, sram_wdata, sram_rdata;

    modport slave (
        input  rq0_valid, rq0_we, rq0_addr, rq0_wdata, rq0_wbe,
        input  rq1_valid, rq1_we, rq1_addr, rq1_wdata, rq1_wbe,
        output rq0_ready, rq1_ready,
        output rs0_valid, rs0_rdata, rs1_valid, rs1_rdata,
        output sram_cen, sram_wen, sram_addr, sram_wmsk, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output rq0_valid, rq0_we, rq0_addr, rq0_wdata, rq0_wbe,
        output rq1_valid, rq1_we, rq1_addr, rq1_wdata, rq1_wbe,
        input  rq0_ready, rq1_ready,
        input  rs0_valid, rs0_rdata, rs1_valid, rs1_rdata,
        input  sram_cen, sram_wen, sram_addr, sram_wmsk, sram_wdata,
        output sram_rdata
    );

endinterface

// File: rtl/sram1024x18_port_arb_rr_arb2.sv
// Two-way arbiter: round-robin on a last-grant pointer, or fixed priority
// to requester 0 when RR_EN is 0. Grants are combinational and off in reset.
module rr_arb2
    import sram1024x18_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    req_id_t    last_q, last_d;
    logic [1:0] gnt;

    always_comb begin
        // NOTE: default assignment first, so no path through this block can infer a latch.
        gnt = 2'b00;
        case (req_i)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (RR_EN != 0 && last_q == 1'b0) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    assign gnt_o = gnt & {2{rst_n}};

    always_comb begin
        last_d = last_q;
        if (gnt_o[1])      last_d = 1'b1;
        else if (gnt_o[0]) last_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is written with <= so every flop sees pre-edge values, whatever the block order.
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end

endmodule

// File: rtl/sram1024x18_port_arb.sv
// Two requesters sharing one SRAM port: registered SRAM commands, a two-stage
// read-return pipeline routed back by requester id, and a conflict counter.
module sram1024x18_port_arb
    import sram1024x18_pkg::*;
#(
    parameter int RR_EN = 1,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram1024x18_port_arb_if.slave bus,
    output logic [CNT_W-1:0]     conflict_cnt
);

    logic [1:0]        gnt;
    logic              accept;
    req_id_t           sel_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata, sel_wbe;

    logic              cen_q, wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wmsk_q, wdata_q;
    rd_entry_t         s1_q, s2_q;
    logic              rs0_valid_q, rs1_valid_q;
    logic [DATA_W-1:0] rs0_rdata_q, rs1_rdata_q;
    logic [CNT_W-1:0]  cnt_q;

    rr_arb2 #(.RR_EN(RR_EN)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({bus.rq1_valid, bus.rq0_valid}),
        .gnt_o (gnt)
    );

    assign bus.rq0_ready = gnt[0];
    assign bus.rq1_ready = gnt[1];
    assign accept        = |gnt;
    assign sel_id        = req_id_t'(gnt[1]);

    always_comb begin
        sel_we    = bus.rq0_we;
        sel_addr  = bus.rq0_addr;
        sel_wdata = bus.rq0_wdata;
        sel_wbe   = bus.rq0_wbe;
        if (gnt[1]) begin
            sel_we    = bus.rq1_we;
            sel_addr  = bus.rq1_addr;
            sel_wdata = bus.rq1_wdata;
            sel_wbe   = bus.rq1_wbe;
        end
    end

    // Address and write data hold their last values when the port is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            wmsk_q  <= '1;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            cen_q   <= 1'b0;
            wen_q   <= ~sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            wmsk_q  <= sel_we ? ~sel_wbe : '1;
        end else begin
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            wmsk_q  <= '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= RD_EMPTY;
            s2_q        <= RD_EMPTY;
            rs0_valid_q <= 1'b0;
            rs1_valid_q <= 1'b0;
            rs0_rdata_q <= '0;
            rs1_rdata_q <= '0;
        end else begin
            s1_q        <= '{valid: accept & ~sel_we, id: sel_id};
            s2_q        <= s1_q;
            rs0_valid_q <= s2_q.valid && s2_q.id == 1'b0;
            rs1_valid_q <= s2_q.valid && s2_q.id == 1'b1;
            if (s2_q.valid && s2_q.id == 1'b0) rs0_rdata_q <= bus.sram_rdata;
            if (s2_q.valid && s2_q.id == 1'b1) rs1_rdata_q <= bus.sram_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (bus.rq0_valid && bus.rq1_valid && cnt_q != '1)
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign bus.sram_cen   = cen_q;
    assign bus.sram_wen   = wen_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wmsk  = wmsk_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.rs0_valid  = rs0_valid_q;
    assign bus.rs1_valid  = rs1_valid_q;
    assign bus.rs0_rdata  = rs0_rdata_q;
    assign bus.rs1_rdata  = rs1_rdata_q;
    assign conflict_cnt   = cnt_q;

endmodule

// File: tb/tb_sram1024x18_port_arb.sv
// Bench for sram1024x18_port_arb: directed vector table, random traffic
// against a transaction-level model, fixed-priority and reset corner cases.
module tb_sram1024x18_port_arb;
    import sram1024x18_pkg::*;

    localparam int RR_EN_TB = 1;

    typedef struct {
        logic        v;
        logic        we;
        logic [9:0]  addr;
        logic [17:0] wdata;
        logic [17:0] wbe;
    } tb_req_t;

    typedef struct {
        tb_req_t     r0, r1;
        logic        er0, er1;
        logic        ers0v;
        logic [17:0] ers0d;
        logic        ers1v;
        logic [17:0] ers1d;
        int          ecnt;
    } vec_t;

    typedef struct {
        int          id;
        logic [17:0] data;
        int          due;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram1024x18_port_arb_if bus();
    sram1024x18_port_arb_if bus_fp();
    logic [15:0] cnt;
    logic [1:0]  cnt_fp;

    sram1024x18_port_arb #(.RR_EN(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .conflict_cnt(cnt)
    );
    sram1024x18_port_arb #(.RR_EN(0), .CNT_W(2)) dut_fp (
        .clk(clk), .rst_n(rst_n), .bus(bus_fp), .conflict_cnt(cnt_fp)
    );

    // Synchronous single-port SRAM behind the main instance.
    logic [17:0] sram_mem [1024];
    always @(posedge clk) begin
        if (!bus.sram_cen) begin
            if (!bus.sram_wen)
                sram_mem[bus.sram_addr] <= (sram_mem[bus.sram_addr] & bus.sram_wmsk)
                                         | (bus.sram_wdata & ~bus.sram_wmsk);
            else
                bus.sram_rdata <= sram_mem[bus.sram_addr];
        end
    end
    assign bus_fp.sram_rdata = '0;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference model.
    logic [17:0] mem_m [1024];
    rsp_t        q[$];
    int          last_g, edge_n, cnt_m;
    logic [17:0] last_rd [2];
    logic        e_cen, e_wen;
    logic [9:0]  e_addr;
    logic [17:0] e_wdata, e_wmsk;
    logic        rdy0, rdy1;

    function automatic tb_req_t idle();
        return '{v: 1'b0, we: 1'b0, addr: '0, wdata: '0, wbe: '0};
    endfunction
    function automatic tb_req_t rd(input logic [9:0] a);
        return '{v: 1'b1, we: 1'b0, addr: a, wdata: '0, wbe: '0};
    endfunction
    function automatic tb_req_t wr(input logic [9:0] a, input logic [17:0] d, input logic [17:0] be);
        return '{v: 1'b1, we: 1'b1, addr: a, wdata: d, wbe: be};
    endfunction
    function automatic vec_t mk(input tb_req_t r0, input tb_req_t r1, input logic er0, input logic er1,
                                input logic s0v, input logic [17:0] s0d,
                                input logic s1v, input logic [17:0] s1d, input int c);
        return '{r0: r0, r1: r1, er0: er0, er1: er1, ers0v: s0v, ers0d: s0d,
                 ers1v: s1v, ers1d: s1d, ecnt: c};
    endfunction

    task automatic model_reset();
        q.delete();
        last_g     = 1;
        cnt_m      = 0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        e_cen = 1'b1; e_wen = 1'b1; e_wmsk = '1; e_addr = '0; e_wdata = '0;
    endtask

    task automatic drive(input tb_req_t r0, input tb_req_t r1);
        bus.rq0_valid = r0.v; bus.rq0_we = r0.we; bus.rq0_addr = r0.addr;
        bus.rq0_wdata = r0.wdata; bus.rq0_wbe = r0.wbe;
        bus.rq1_valid = r1.v; bus.rq1_we = r1.we; bus.rq1_addr = r1.addr;
        bus.rq1_wdata = r1.wdata; bus.rq1_wbe = r1.wbe;
    endtask

    // Wait for the falling edge and compare all registered outputs to the model.
    task automatic sample();
        logic        ev [2];
        logic [17:0] ed [2];
        @(negedge clk);
        ev[0] = 1'b0; ev[1] = 1'b0;
        ed[0] = last_rd[0]; ed[1] = last_rd[1];
        if (q.size() > 0 && q[0].due == edge_n) begin
            ev[q[0].id]      = 1'b1;
            ed[q[0].id]      = q[0].data;
            last_rd[q[0].id] = q[0].data;
            void'(q.pop_front());
        end
        check("rs0_valid", bus.rs0_valid, ev[0]);
        check("rs1_valid", bus.rs1_valid, ev[1]);
        check("rs0_rdata", bus.rs0_rdata, ed[0]);
        check("rs1_rdata", bus.rs1_rdata, ed[1]);
        check("sram_cen", bus.sram_cen, e_cen);
        check("sram_wen", bus.sram_wen, e_wen);
        check("sram_addr", bus.sram_addr, e_addr);
        check("sram_wdata", bus.sram_wdata, e_wdata);
        check("sram_wmsk", bus.sram_wmsk, e_wmsk);
        check("conflict_cnt", cnt, cnt_m);
    endtask

    // Drive one cycle of requests, check grants, and advance the model past the next edge.
    task automatic apply(input tb_req_t r0, input tb_req_t r1);
        int      w;
        tb_req_t win;
        drive(r0, r1);
        #1;
        rdy0 = bus.rq0_ready;
        rdy1 = bus.rq1_ready;
        if (r0.v && r1.v) w = (RR_EN_TB != 0) ? 1 - last_g : 0;
        else if (r0.v)    w = 0;
        else if (r1.v)    w = 1;
        else              w = -1;
        check("rq0_ready", rdy0, w == 0);
        check("rq1_ready", rdy1, w == 1);
        edge_n++;
        if (r0.v && r1.v && cnt_m < 65535) cnt_m++;
        if (w < 0) begin
            e_cen = 1'b1; e_wen = 1'b1; e_wmsk = '1;
        end else begin
            win     = (w == 0) ? r0 : r1;
            last_g  = w;
            e_cen   = 1'b0;
            e_wen   = ~win.we;
            e_addr  = win.addr;
            e_wdata = win.wdata;
            if (win.we) begin
                e_wmsk = ~win.wbe;
                mem_m[win.addr] = (mem_m[win.addr] & ~win.wbe) | (win.wdata & win.wbe);
            end else begin
                e_wmsk = '1;
                q.push_back('{id: w, data: mem_m[win.addr], due: edge_n + 2});
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cen"}, bus.sram_cen, 1);
        check({tag, "_wen"}, bus.sram_wen, 1);
        check({tag, "_wmsk"}, bus.sram_wmsk, 18'h3FFFF);
        check({tag, "_addr"}, bus.sram_addr, 0);
        check({tag, "_wdata"}, bus.sram_wdata, 0);
        check({tag, "_rs0_valid"}, bus.rs0_valid, 0);
        check({tag, "_rs1_valid"}, bus.rs1_valid, 0);
        check({tag, "_rs0_rdata"}, bus.rs0_rdata, 0);
        check({tag, "_rs1_rdata"}, bus.rs1_rdata, 0);
        check({tag, "_cnt"}, cnt, 0);
        check({tag, "_rq0_ready"}, bus.rq0_ready, 0);
        check({tag, "_rq1_ready"}, bus.rq1_ready, 0);
        check({tag, "_fp_rq0_ready"}, bus_fp.rq0_ready, 0);
        check({tag, "_fp_cnt"}, cnt_fp, 0);
    endtask

    vec_t vt [29];

    initial begin
        tb_req_t r0, r1;

        vt[0]  = mk(wr(5, 18'h2A5A5, 18'h3FFFF), idle(), 1, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(rd(5), idle(), 1, 0, 0, 0, 0, 0, 0);
        vt[2]  = mk(idle(), idle(), 0, 0, 0, 0, 0, 0, 0);
        vt[3]  = mk(idle(), idle(), 0, 0, 0, 0, 0, 0, 0);
        vt[4]  = mk(idle(), idle(), 0, 0, 1, 18'h2A5A5, 0, 0, 0);
        vt[5]  = mk(idle(), idle(), 0, 0, 0, 0, 0, 0, 0);
        vt[6]  = mk(wr(9, 18'h3FFFF, 18'h3FFFF), idle(), 1, 0, 0, 0, 0, 0, 0);
        vt[7]  = mk(wr(9, 18'h00000, 18'h000FF), idle(), 1, 0, 0, 0, 0, 0, 0);
        vt[8]  = mk(rd(9), idle(), 1, 0, 0, 0, 0, 0, 0);
        vt[9]  = mk(idle(), idle(), 0, 0, 0, 0, 0, 0, 0);
        vt[10] = mk(idle(), idle(), 0, 0, 0, 0, 0, 0, 0);
        vt[11] = mk(idle(), idle(), 0, 0, 1, 18'h3FF00, 0, 0, 0);
        vt[12] = mk(idle(), wr(7, 18'h01234, 18'h3FFFF), 0, 1, 0, 0, 0, 0, 0);
        vt[13] = mk(idle(), rd(7), 0, 1, 0, 0, 0, 0, 0);
        vt[14] = mk(idle(), idle(), 0, 0, 0, 0, 0, 0, 0);
        vt[15] = mk(idle(), idle(), 0, 0, 0, 0, 0, 0, 0);
        vt[16] = mk(idle(), idle(), 0, 0, 0, 0, 1, 18'h01234, 0);
        vt[17] = mk(idle(), wr(1, 18'h00011, 18'h3FFFF), 0, 1, 0, 0, 0, 0, 0);
        vt[18] = mk(idle(), wr(2, 18'h00022, 18'h3FFFF), 0, 1, 0, 0, 0, 0, 0);
        vt[19] = mk(idle(), wr(3, 18'h00033, 18'h3FFFF), 0, 1, 0, 0, 0, 0, 0);
        vt[20] = mk(idle(), wr(4, 18'h00044, 18'h3FFFF), 0, 1, 0, 0, 0, 0, 0);
        vt[21] = mk(rd(1), rd(2), 1, 0, 0, 0, 0, 0, 0);
        vt[22] = mk(rd(3), rd(2), 0, 1, 0, 0, 0, 0, 1);
        vt[23] = mk(rd(3), rd(4), 1, 0, 0, 0, 0, 0, 2);
        vt[24] = mk(rd(1), rd(4), 0, 1, 1, 18'h00011, 0, 0, 3);
        vt[25] = mk(idle(), idle(), 0, 0, 0, 0, 1, 18'h00022, 4);
        vt[26] = mk(idle(), idle(), 0, 0, 1, 18'h00033, 0, 0, 4);
        vt[27] = mk(idle(), idle(), 0, 0, 0, 0, 1, 18'h00044, 4);
        vt[28] = mk(idle(), idle(), 0, 0, 0, 0, 0, 0, 4);

        // Reset with requests present: readies and all outputs at reset values.
        edge_n = 0;
        model_reset();
        rst_n = 1'b0;
        drive(rd(3), rd(4));
        bus_fp.rq0_valid = 1'b1; bus_fp.rq1_valid = 1'b1; bus_fp.rq0_we = 1'b0; bus_fp.rq1_we = 1'b0;
        bus_fp.rq0_addr = '0; bus_fp.rq1_addr = '0; bus_fp.rq0_wdata = '0; bus_fp.rq1_wdata = '0;
        bus_fp.rq0_wbe = '0; bus_fp.rq1_wbe = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("por");
        @(negedge clk);
        rst_n = 1'b1;
        drive(idle(), idle());
        bus_fp.rq0_valid = 1'b0; bus_fp.rq1_valid = 1'b0;

        // Fixed priority with a 2-bit counter: rq0 always wins, count saturates at 3.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) check("fp_cnt_3", cnt_fp, 3);
            bus_fp.rq0_valid = 1'b1; bus_fp.rq1_valid = 1'b1;
            bus_fp.rq0_addr = 10'(i); bus_fp.rq1_addr = 10'(i + 8);
            #1;
            check("fp_rq0_ready", bus_fp.rq0_ready, 1);
            check("fp_rq1_ready", bus_fp.rq1_ready, 0);
        end
        @(negedge clk);
        check("fp_cnt_sat", cnt_fp, 3);
        bus_fp.rq0_valid = 1'b0; bus_fp.rq1_valid = 1'b0;
        #1;
        check("fp_idle_ready", bus_fp.rq0_ready, 0);

        // Directed vector table on the round-robin instance.
        for (int i = 0; i < 29; i++) begin
            sample();
            check($sformatf("vec%0d_rs0_valid", i), bus.rs0_valid, vt[i].ers0v);
            check($sformatf("vec%0d_rs1_valid", i), bus.rs1_valid, vt[i].ers1v);
            if (vt[i].ers0v) check($sformatf("vec%0d_rs0_rdata", i), bus.rs0_rdata, vt[i].ers0d);
            if (vt[i].ers1v) check($sformatf("vec%0d_rs1_rdata", i), bus.rs1_rdata, vt[i].ers1d);
            check($sformatf("vec%0d_cnt", i), cnt, vt[i].ecnt);
            apply(vt[i].r0, vt[i].r1);
            check($sformatf("vec%0d_rq0_ready", i), rdy0, vt[i].er0);
            check($sformatf("vec%0d_rq1_ready", i), rdy1, vt[i].er1);
        end

        // Preload the random address window so every read has a known value.
        for (int a = 0; a < 16; a++) begin
            sample();
            if (a[0]) apply(idle(), wr(10'(a), 18'($urandom), 18'h3FFFF));
            else      apply(wr(10'(a), 18'($urandom), 18'h3FFFF), idle());
        end

        for (int n = 0; n < 600; n++) begin
            r0 = '{v: ($urandom_range(0, 3) != 0), we: ($urandom_range(0, 2) == 0),
                   addr: 10'($urandom_range(0, 15)), wdata: 18'($urandom),
                   wbe: ($urandom_range(0, 1) != 0) ? 18'h3FFFF : 18'($urandom)};
            r1 = '{v: ($urandom_range(0, 3) != 0), we: ($urandom_range(0, 2) == 0),
                   addr: 10'($urandom_range(0, 15)), wdata: 18'($urandom),
                   wbe: ($urandom_range(0, 1) != 0) ? 18'h3FFFF : 18'($urandom)};
            sample();
            apply(r0, r1);
        end
        repeat (4) begin
            sample();
            apply(idle(), idle());
        end

        // Reset one cycle after a read is accepted: the read must never return.
        sample();
        apply(rd(5), idle());
        @(negedge clk);
        rst_n = 1'b0;
        drive(rd(6), rd(7));
        #1;
        check_reset_state("mid");
        @(negedge clk);
        check_reset_state("mid_hold");
        rst_n = 1'b1;
        model_reset();
        apply(idle(), idle());
        repeat (6) begin
            sample();
            apply(idle(), idle());
        end
        sample();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
